// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state encoding,
// default timing constants and small width helpers.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    PLL_RST   = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  localparam int PLL_RST_CYCLES_DEF      = 16;
  localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
  localparam int LOCK_TIMEOUT_CYCLES_DEF = 65536;
  localparam int STAGGER_CYCLES_DEF      = 8;
  localparam int NUM_DOMAINS_DEF         = 4;

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// Status/control bundle between the PLL reset sequencer (master) and the
// PLL plus the clock domains it resets (slave).
interface pll_reset_sequencer_if
  import pll_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = NUM_DOMAINS_DEF
);

  logic                   pll_locked;
  logic                   pll_rst;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   all_ready;
  logic                   lock_lost;
  logic [7:0]             retry_count;
  logic [1:0]             state;

  modport master (
    input  pll_locked,
    output pll_rst,
    output domain_rst,
    output all_ready,
    output lock_lost,
    output retry_count,
    output state
  );

  modport slave (
    output pll_locked,
    input  pll_rst,
    input  domain_rst,
    input  all_ready,
    input  lock_lost,
    input  retry_count,
    input  state
  );

endinterface

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer bringing the asynchronous PLL lock flag into refclk.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Sequences PLL reset, waits for a stable lock (retrying on timeout), then
// releases the per-domain resets one at a time and supervises lock afterwards.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
  parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int STAGGER_CYCLES      = STAGGER_CYCLES_DEF,
  parameter int NUM_DOMAINS         = NUM_DOMAINS_DEF
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);

  localparam int REL_CYCLES = NUM_DOMAINS * STAGGER_CYCLES;
  localparam int CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, REL_CYCLES));
  localparam int STB_W = cnt_width(LOCK_STABLE_CYCLES);

  seq_state_e             st;
  logic [CNT_W-1:0]       cnt;
  logic [STB_W-1:0]       stable_cnt;
  logic                   lock_s;
  logic                   pll_rst_r;
  logic [NUM_DOMAINS-1:0] domain_rst_r;
  logic                   all_ready_r;
  logic                   lock_lost_r;
  logic [7:0]             retry_count_r;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (bus.pll_locked),
    .q   (lock_s)
  );

  // A bit stays in reset until 'elapsed' reaches its slot in the stagger.
  function automatic logic [NUM_DOMAINS-1:0] held_mask(input int elapsed);
    logic [NUM_DOMAINS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_DOMAINS; i++) begin
      m[i] = ((i * STAGGER_CYCLES) > elapsed);
    end
    return m;
  endfunction

  always_ff @(posedge refclk) begin
    if (rst) begin
      st            <= PLL_RST;
      cnt           <= '0;
      stable_cnt    <= '0;
      pll_rst_r     <= 1'b1;
      domain_rst_r  <= '1;
      all_ready_r   <= 1'b0;
      lock_lost_r   <= 1'b0;
      retry_count_r <= 8'd0;
    end else begin
      case (st)
        PLL_RST: begin
          if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) begin
            st         <= WAIT_LOCK;
            cnt        <= '0;
            stable_cnt <= '0;
            pll_rst_r  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        WAIT_LOCK: begin
          // Reaching stability wins over a timeout landing on the same clock.
          if (lock_s && (stable_cnt == STB_W'(LOCK_STABLE_CYCLES - 1))) begin
            st           <= RELEASE;
            cnt          <= '0;
            stable_cnt   <= '0;
            domain_rst_r <= held_mask(0);
          end else if (cnt == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
            st         <= PLL_RST;
            cnt        <= '0;
            stable_cnt <= '0;
            pll_rst_r  <= 1'b1;
            if (retry_count_r != 8'hFF) begin
              retry_count_r <= retry_count_r + 8'd1;
            end
          end else begin
            cnt        <= cnt + CNT_W'(1);
            stable_cnt <= lock_s ? (stable_cnt + STB_W'(1)) : '0;
          end
        end

        RELEASE, RUN: begin
          if (!lock_s) begin
            st           <= PLL_RST;
            cnt          <= '0;
            stable_cnt   <= '0;
            pll_rst_r    <= 1'b1;
            domain_rst_r <= '1;
            all_ready_r  <= 1'b0;
            lock_lost_r  <= 1'b1;
          end else if (st == RELEASE) begin
            if (cnt == CNT_W'(REL_CYCLES - 1)) begin
              st           <= RUN;
              cnt          <= '0;
              domain_rst_r <= '0;
              all_ready_r  <= 1'b1;
            end else begin
              cnt          <= cnt + CNT_W'(1);
              domain_rst_r <= held_mask(int'(cnt) + 1);
            end
          end
        end

        default: begin
          st <= PLL_RST;
        end
      endcase
    end
  end

  assign bus.pll_rst     = pll_rst_r;
  assign bus.domain_rst  = domain_rst_r;
  assign bus.all_ready   = all_ready_r;
  assign bus.lock_lost   = lock_lost_r;
  assign bus.retry_count = retry_count_r;
  assign bus.state       = st;

endmodule

// File: doc/pll_reset_sequencer.md
PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 Parameter: PLL_RST_CYCLES, 16, clocks pll_rst is held high per PLL reset attempt.
REQ-002 Parameter: LOCK_STABLE_CYCLES, 1024, consecutive synchronized-lock clocks required before domain release.
REQ-003 Parameter: LOCK_TIMEOUT_CYCLES, 65536, maximum clocks spent in WAIT_LOCK before a PLL retry.
REQ-004 Parameter: STAGGER_CYCLES, 8, clocks between successive domain reset releases.
REQ-005 Parameter: NUM_DOMAINS, 4, number of clock-domain resets (pixel, pixel 90 deg, CPU/draw queue, VRAM).
REQ-006 Port: refclk  input  1  free-running PLL reference clock; the sole clock of this block.
REQ-007 Port: rst  input  1  synchronous, active-high reset.
REQ-008 Port: pll_locked  input  1  PLL locked indication, asynchronous to refclk.
REQ-009 Port: pll_rst  output  1  reset to the PLL, active high.
REQ-010 Port: domain_rst  output  NUM_DOMAINS  per-domain reset, active high, bit 0 released first.
REQ-011 Port: all_ready  output  1  high only in RUN.
REQ-012 Port: lock_lost  output  1  sticky flag, set on any lock loss after release began.
REQ-013 Port: retry_count  output  8  count of lock timeouts, saturating at 255.
REQ-014 Port: state  output  2  current FSM state, for debug.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lock_s is the second stage (2-clock latency).
REQ-016 The FSM SHALL use states PLL_RST=0, WAIT_LOCK=1, RELEASE=2, RUN=3.
REQ-017 PLL_RST: pll_rst=1, domain_rst all ones; after exactly PLL_RST_CYCLES clocks -> WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0, domain_rst all ones; stable counter increments when lock_s=1 and clears to 0 when lock_s=0.
REQ-019 WAIT_LOCK: stable counter reaching LOCK_STABLE_CYCLES -> RELEASE; this SHALL take priority over a timeout occurring on the same clock.
REQ-020 WAIT_LOCK: total clocks in state reaching LOCK_TIMEOUT_CYCLES without stability -> PLL_RST and retry_count increments, saturating at 255.
REQ-021 RELEASE: domain_rst[0] SHALL deassert on the first RELEASE clock; domain_rst[i] SHALL deassert i*STAGGER_CYCLES clocks later.
REQ-022 Released domain_rst bits SHALL stay low; -> RUN STAGGER_CYCLES clocks after domain_rst[NUM_DOMAINS-1] deasserts.
REQ-023 RUN: all_ready=1, domain_rst all zeros, pll_rst=0.
REQ-024 lock_s=0 in RELEASE or RUN: on the next clock domain_rst SHALL be all ones, all_ready=0, lock_lost=1, state=PLL_RST.
REQ-025 lock_lost SHALL clear only on rst; retry_count SHALL not clear on lock loss.
REQ-026 All counters and status outputs SHALL be reset on every state entry except retry_count and lock_lost.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 While rst=1 the block SHALL hold state=PLL_RST, pll_rst=1, domain_rst all ones, all_ready=0, lock_lost=0, retry_count=0, counters=0, synchronizer flops=0.
REQ-029 rst asserted in any state, including mid-RELEASE, SHALL take effect on the next refclk edge and override all other transitions.
REQ-030 After rst deasserts, PLL_RST SHALL last the full PLL_RST_CYCLES.

Structure
REQ-031 Package pll_seq_pkg SHALL hold the state enumeration and default parameter constants.
REQ-032 The synchronizer SHALL be sub-module sync_2ff; the FSM and counters are in pll_reset_sequencer.

Verification (bench parameters PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=16, LOCK_TIMEOUT_CYCLES=64, STAGGER_CYCLES=2, NUM_DOMAINS=4)
REQ-033 Clean start: release rst, hold pll_locked=1 -> pll_rst high 4 clocks; domain_rst 1111 -> 1110 -> 1100 -> 1000 -> 0000 at 2-clock spacing; all_ready rises 2 clocks later.
REQ-034 Lock glitch: pll_locked drops 3 clocks at stable count 10 -> stable counter restarts; release begins 16 clocks after lock returns plus 2-clock synchronizer latency.
REQ-035 Timeout: pll_locked held 0 -> PLL_RST re-entered every 68 clocks; retry_count 1, 2, 3; saturation checked by forcing 300 timeouts -> 255.
REQ-036 Loss in RUN: drop pll_locked -> domain_rst=1111, all_ready=0, and lock_lost=1 exactly 3 clocks after the drop; re-sequence completes; lock_lost stays 1.
REQ-037 Reset mid-RELEASE: assert rst when domain_rst=1100 -> next clock domain_rst=1111, pll_rst=1, lock_lost=0, retry_count=0.
